// File: rtl/scrmbl_pipe_engine_if.sv
// Stream bundle for the scrambling engine: input beat (payload + entropy) and
// scrambled output word with its selection-code sideband.
interface scrmbl_pipe_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 32,
  parameter int SEL_W  = 5
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] data_i;
  logic [OUT_W-1:0]  entropy_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [OUT_W-1:0]  data_o;
  logic [SEL_W-1:0]  sel_o;

  modport slave (
    input  in_valid_i, data_i, entropy_i, out_ready_i,
    output in_ready_o, out_valid_o, data_o, sel_o
  );

  modport master (
    output in_valid_i, data_i, entropy_i, out_ready_i,
    input  in_ready_o, out_valid_o, data_o, sel_o
  );
endinterface

// File: rtl/scrmbl_pipe_engine.sv
// Two-stage valid/ready scrambler: drops DATA_W payload bits into code-dependent
// slots of an OUT_W entropy word and fills the rest with rotated entropy.
module scrmbl_pipe_engine #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 32,
  parameter int KEY_W  = 64,
  parameter int SEL_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   seed_load_i,
  input  logic [KEY_W-1:0]       seed_i,
  input  logic                   roll_en_i,
  scrmbl_pipe_engine_if.slave    bus,
  output logic [15:0]            beat_cnt_o
);

  localparam int          STRIDE    = OUT_W / DATA_W;
  localparam logic [15:0] LFSR_INIT = 16'hACE1;

  // Data bit i lands at (S + i*STRIDE) mod OUT_W; all other bits take entropy[(p+S) mod OUT_W].
  function automatic logic [OUT_W-1:0] map_word(input logic [DATA_W-1:0] d,
                                                input logic [OUT_W-1:0]  e,
                                                input logic [SEL_W-1:0]  s);
    logic [OUT_W-1:0] w;
    logic [SEL_W-1:0] idx;
    w = {OUT_W{1'b0}};
    for (int p = 0; p < OUT_W; p++) begin
      idx  = SEL_W'(p) + s;
      w[p] = e[idx];
    end
    for (int i = 0; i < DATA_W; i++) begin
      idx    = s + SEL_W'(i * STRIDE);
      w[idx] = d[i];
    end
    return w;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic              rdy_en_q,   rdy_en_d;
  logic [SEL_W-1:0]  key_sel_q,  key_sel_d;
  logic [15:0]       lfsr_q,     lfsr_d;
  logic              s1_valid_q, s1_valid_d;
  logic [OUT_W-1:0]  s1_data_q,  s1_data_d;
  logic [SEL_W-1:0]  s1_sel_q,   s1_sel_d;
  logic              s2_valid_q, s2_valid_d;
  logic [OUT_W-1:0]  s2_data_q,  s2_data_d;
  logic [SEL_W-1:0]  s2_sel_q,   s2_sel_d;
  logic [15:0]       cnt_q,      cnt_d;

  logic              s2_load_s;
  logic              s1_move_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              out_hs_s;
  logic [SEL_W-1:0]  sel_s;
  logic              unused_seed_s;

  // Only the code bits and the LFSR seed bits of the key are consumed.
  assign unused_seed_s = ^seed_i;

  // Handshake decode, pipeline advance and next-state computation.
  always_comb begin
    s2_load_s  = ~s2_valid_q | bus.out_ready_i;
    s1_move_s  = s1_valid_q & s2_load_s;
    in_ready_s = rdy_en_q & ~seed_load_i & (~s1_valid_q | s1_move_s);
    accept_s   = bus.in_valid_i & in_ready_s;
    out_hs_s   = s2_valid_q & bus.out_ready_i;
    sel_s      = roll_en_i ? lfsr_q[SEL_W-1:0] : key_sel_q;

    rdy_en_d   = 1'b1;
    key_sel_d  = key_sel_q;
    lfsr_d     = lfsr_q;
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sel_d   = s1_sel_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sel_d   = s2_sel_q;
    cnt_d      = cnt_q;

    if (accept_s) begin
      s1_valid_d = 1'b1;
      s1_data_d  = map_word(bus.data_i, bus.entropy_i, sel_s);
      s1_sel_d   = sel_s;
    end else if (s1_move_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end

    if (s1_move_s) begin
      s2_valid_d = 1'b1;
      s2_data_d  = s1_data_q;
      s2_sel_d   = s1_sel_q;
    end else if (s2_load_s) begin
      s2_valid_d = 1'b0;
    end else begin
      s2_valid_d = s2_valid_q;
    end

    // A seed strobe wins over a same-cycle output handshake for the counter.
    if (seed_load_i) begin
      key_sel_d = seed_i[SEL_W-1:0];
      lfsr_d    = (seed_i[15:0] == 16'h0000) ? LFSR_INIT : seed_i[15:0];
      cnt_d     = 16'h0000;
    end else begin
      if (accept_s && roll_en_i) begin
        lfsr_d = lfsr_next(lfsr_q);
      end else begin
        lfsr_d = lfsr_q;
      end
      if (out_hs_s) begin
        cnt_d = cnt_q + 16'h0001;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // State registers; reset flushes both stages and holds off input until the first clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q   <= 1'b0;
      key_sel_q  <= {SEL_W{1'b0}};
      lfsr_q     <= LFSR_INIT;
      s1_valid_q <= 1'b0;
      s1_data_q  <= {OUT_W{1'b0}};
      s1_sel_q   <= {SEL_W{1'b0}};
      s2_valid_q <= 1'b0;
      s2_data_q  <= {OUT_W{1'b0}};
      s2_sel_q   <= {SEL_W{1'b0}};
      cnt_q      <= 16'h0000;
    end else begin
      rdy_en_q   <= rdy_en_d;
      key_sel_q  <= key_sel_d;
      lfsr_q     <= lfsr_d;
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_sel_q   <= s1_sel_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sel_q   <= s2_sel_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready_o  = in_ready_s;
  assign bus.out_valid_o = s2_valid_q;
  assign bus.data_o      = s2_data_q;
  assign bus.sel_o       = s2_sel_q;
  assign beat_cnt_o      = cnt_q;

endmodule

// File: tb/tb_scrmbl_pipe_engine.sv
// Directed plus randomized bench for scrmbl_pipe_engine, checked against a
// queue-based reference model built from rotate/insert arithmetic.
module tb_scrmbl_pipe_engine;
  localparam int DW = 8;
  localparam int OW = 32;
  localparam int KW = 64;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          seed_load;
  logic [KW-1:0] seed;
  logic          roll;
  logic [15:0]   beat_cnt;

  always #5 clk = ~clk;

  scrmbl_pipe_engine_if #(.DATA_W(DW), .OUT_W(OW), .SEL_W(SW)) bus ();

  scrmbl_pipe_engine #(.DATA_W(DW), .OUT_W(OW), .KEY_W(KW), .SEL_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load_i (seed_load),
    .seed_i      (seed),
    .roll_en_i   (roll),
    .bus         (bus),
    .beat_cnt_o  (beat_cnt)
  );

  typedef struct packed {
    logic [31:0] w;
    logic [4:0]  s;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  beat_t       expq[$];
  logic [4:0]  obs_sel[$];
  logic [4:0]  m_key;
  logic [15:0] m_lfsr;
  logic [15:0] m_cnt;
  int          acc_cnt;
  int          acc_total;
  bit          last_acc;
  bit          hold_v;
  logic [31:0] hold_d;
  logic [4:0]  hold_s;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Output word = entropy rotated right by S, then payload bits inserted at stride slots.
  function automatic logic [31:0] ref_map(input logic [7:0] d, input logic [31:0] e, input int s);
    logic [63:0] ee;
    logic [31:0] w;
    ee = {e, e};
    w  = 32'(ee >> s);
    for (int i = 0; i < DW; i++) w[(s + i * (OW / DW)) % OW] = d[i];
    return w;
  endfunction

  function automatic logic [15:0] ref_step(input logic [15:0] l);
    return {l[14:0], ^(l & 16'hB400)};
  endfunction

  task automatic model_reset();
    expq.delete();
    m_key   = 5'd0;
    m_lfsr  = 16'hACE1;
    m_cnt   = 16'd0;
    acc_cnt = 0;
    hold_v  = 1'b0;
  endtask

  // One clock: sample handshakes just before the rising edge, update model, check after.
  task automatic cycle();
    bit         acc;
    bit         ohs;
    beat_t      b;
    logic [4:0] s;
    #4;
    acc      = bus.in_valid_i & bus.in_ready_o;
    ohs      = bus.out_valid_o & bus.out_ready_i;
    last_acc = acc;
    if (seed_load) chk("ready_low_on_seed", 32'(bus.in_ready_o), 32'd0);
    if (ohs) begin
      chk("beat_available", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        b = expq.pop_front();
        chk("out_data", bus.data_o, b.w);
        chk("out_sel", 32'(bus.sel_o), 32'(b.s));
      end
      obs_sel.push_back(bus.sel_o);
    end
    hold_v = bus.out_valid_o & ~bus.out_ready_i;
    hold_d = bus.data_o;
    hold_s = bus.sel_o;
    if (acc) begin
      s = roll ? m_lfsr[4:0] : m_key;
      expq.push_back({ref_map(bus.data_i, bus.entropy_i, int'(s)), s});
      if (roll) m_lfsr = ref_step(m_lfsr);
      acc_cnt++;
    end
    if (seed_load) begin
      m_key   = seed[4:0];
      m_lfsr  = (seed[15:0] == 16'h0000) ? 16'hACE1 : seed[15:0];
      m_cnt   = 16'd0;
      acc_cnt = 0;
    end else if (ohs) begin
      m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
    if (hold_v) begin
      chk("hold_data", bus.data_o, hold_d);
      chk("hold_sel", 32'(bus.sel_o), 32'(hold_s));
    end
  endtask

  task automatic load_seed(input logic [KW-1:0] k);
    bus.in_valid_i = 1'b0;
    seed           = k;
    seed_load      = 1'b1;
    cycle();
    seed_load      = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (expq.size() == 0 && !bus.out_valid_o) break;
      cycle();
    end
    chk("drained", 32'(expq.size()), 32'd0);
  endtask

  task automatic send1(input logic [7:0] d, input logic [31:0] e,
                       input logic [31:0] exp_w, input logic [4:0] exp_s, input string tag);
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.data_i      = d;
    bus.entropy_i   = e;
    last_acc        = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (last_acc) break;
    end
    chk({tag, "_accepted"}, 32'(last_acc), 32'd1);
    bus.in_valid_i = 1'b0;
    chk({tag, "_lat1"}, 32'(bus.out_valid_o), 32'd0);
    cycle();
    chk({tag, "_lat2"}, 32'(bus.out_valid_o), 32'd1);
    chk({tag, "_data"}, bus.data_o, exp_w);
    chk({tag, "_sel"}, 32'(bus.sel_o), 32'(exp_s));
    cycle();
  endtask

  initial begin
    logic [4:0] exp_roll [5];
    logic [7:0] d8;
    logic [31:0] e32;
    exp_roll = '{5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

    rst_n           = 1'b0;
    seed_load       = 1'b0;
    seed            = '0;
    roll            = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.data_i      = 8'h00;
    bus.entropy_i   = 32'h0;
    bus.out_ready_i = 1'b1;
    acc_total       = 0;
    model_reset();

    // Reset state
    #12;
    chk("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_sel", 32'(bus.sel_o), 32'd0);
    chk("rst_cnt", 32'(beat_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("ready_after_rst", 32'(bus.in_ready_o), 32'd1);

    // Fixed-code directed vectors
    load_seed(64'd0);
    send1(8'hFF, 32'h0, 32'h11111111, 5'd0, "t1");
    load_seed(64'd3);
    send1(8'h00, 32'hFFFFFFFF, 32'h77777777, 5'd3, "t2a");
    load_seed(64'd1);
    send1(8'h00, 32'h00000001, 32'h80000000, 5'd1, "t2b");

    // Rolling code from seed 1, five back-to-back beats
    load_seed(64'd1);
    roll = 1'b1;
    obs_sel.delete();
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_i    = 8'($urandom);
      bus.entropy_i = $urandom;
      cycle();
    end
    chk("roll_accepts", 32'(acc_cnt), 32'd5);
    drain();
    chk("roll_count", 32'(obs_sel.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_sel.size(); i++) chk("roll_sel", 32'(obs_sel[i]), 32'(exp_roll[i]));
    load_seed(64'd0);
    d8  = 8'h5A;
    e32 = 32'hC3A5_0F96;
    send1(d8, e32, ref_map(d8, e32, 1), 5'h01, "t3_zero_seed");
    roll = 1'b0;

    // Backpressure
    load_seed(64'h1234_5678_9ABC_DE0B);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.data_i    = 8'($urandom);
      bus.entropy_i = $urandom;
      cycle();
    end
    chk("bp_accepts", 32'(acc_cnt), 32'd2);
    chk("bp_ready_low", 32'(bus.in_ready_o), 32'd0);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_i    = 8'($urandom);
      bus.entropy_i = $urandom;
      cycle();
    end
    drain();
    chk("bp_beat_cnt", 32'(beat_cnt), 32'(acc_cnt));

    // Seed strobe with both stages full and a simultaneous output handshake
    load_seed(64'd5);
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.data_i    = 8'($urandom);
      bus.entropy_i = $urandom;
      cycle();
    end
    chk("seed_fill", 32'(acc_cnt), 32'd2);
    obs_sel.delete();
    bus.in_valid_i  = 1'b1;
    bus.out_ready_i = 1'b1;
    seed            = 64'd9;
    seed_load       = 1'b1;
    cycle();
    seed_load = 1'b0;
    chk("seed_cnt_zero", 32'(beat_cnt), 32'd0);
    drain();
    chk("seed_old_count", 32'(obs_sel.size()), 32'd2);
    for (int i = 0; i < obs_sel.size(); i++) chk("seed_old_sel", 32'(obs_sel[i]), 32'd5);

    // Asynchronous reset mid-stream
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.data_i    = 8'($urandom);
      bus.entropy_i = $urandom;
      cycle();
    end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid_o), 32'd0);
    chk("mid_rst_cnt", 32'(beat_cnt), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready_o), 32'd0);
    model_reset();
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    rst_n          = 1'b1;
    cycle();
    chk("mid_rst_ready_back", 32'(bus.in_ready_o), 32'd1);

    // Randomized traffic
    for (int n = 0; n < 40000 && acc_total < 10000; n++) begin
      bus.in_valid_i  = ($urandom_range(3) != 0);
      bus.out_ready_i = ($urandom_range(3) != 0);
      bus.data_i      = 8'($urandom);
      bus.entropy_i   = $urandom;
      roll            = 1'($urandom);
      seed_load       = ($urandom_range(255) == 0);
      seed            = {$urandom, $urandom};
      if ($urandom_range(3) == 0) seed[15:0] = 16'h0000;
      cycle();
      if (last_acc) acc_total++;
    end
    seed_load = 1'b0;
    drain();
    chk("rand_beats", 32'(acc_total >= 10000), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
